// File: rtl/uma_pkg.sv
// Shared types and default sizing for the unified memory arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package uma_pkg;

    localparam int UMA_ADDR_W       = 32;
    localparam int UMA_DATA_W       = 32;
    localparam int UMA_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        UMA_IDLE  = 2'd0,
        UMA_ISSUE = 2'd1,
        UMA_RESP  = 2'd2
    } uma_state_t;

    typedef enum logic {
        UMA_OWN_IF = 1'b0,
        UMA_OWN_DM = 1'b1
    } uma_owner_t;

endpackage

// File: rtl/uma_starve_ctr.sv
// Fetch starvation counter: counts data grants taken while fetch is waiting.
// Latency: at_limit reflects grants up to the previous cycle (registered count).
// Backpressure: none; it only observes grant decisions made by the arbiter.
//
// Ports: clk/rst (async active-high), if_req, idle (arbiter in IDLE),
//        if_grant/dm_grant (grant taken this cycle), at_limit (count == limit).
module uma_starve_ctr
    import uma_pkg::*;
#(
    parameter int STARVE_LIMIT = UMA_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic idle,
    input  logic if_grant,
    input  logic dm_grant,
    output logic at_limit
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (if_grant || (idle && !if_req)) begin
            // Fetch got served, or is not waiting at all: nothing owed.
            cnt_q <= '0;
        end else if (dm_grant && if_req && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign at_limit = (cnt_q == LIMIT);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data stage.
// Latency: request seen in IDLE -> mem_req next cycle; 2 cycles minimum to *_valid.
// Backpressure: holds mem_req/fields until mem_gnt; requesters stall via *_stall.
//
// Ports: fetch side (if_req/if_addr/if_flush -> if_rdata/if_valid/if_stall),
//        data side (dm_req/dm_we/dm_addr/dm_wdata/dm_be -> dm_rdata/dm_valid/dm_stall),
//        memory side (registered mem_req/mem_we/mem_addr/mem_wdata/mem_be,
//        mem_gnt/mem_rvalid/mem_rdata in), busy = not IDLE.
// Build option: define UMA_FAIRNESS_EN to force a fetch grant after STARVE_LIMIT
// consecutive data grants taken while fetch waits; otherwise strict data priority.
module unified_mem_arbiter
    import uma_pkg::*;
#(
    parameter int ADDR_W       = UMA_ADDR_W,
    parameter int DATA_W       = UMA_DATA_W,
    parameter int STARVE_LIMIT = UMA_STARVE_LIMIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    output logic                if_stall,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_valid,
    output logic                dm_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    uma_state_t state_q, state_d;
    uma_owner_t owner_q;
    logic       stale_q;

    logic in_idle;
    logic grant_if;
    logic grant_dm;
    logic fetch_first;
    logic resp_fire;
    logic if_hit;
    logic dm_hit;

    assign in_idle = (state_q == UMA_IDLE);

`ifdef UMA_FAIRNESS_EN
    logic at_limit;

    uma_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .idle     (in_idle),
        .if_grant (grant_if),
        .dm_grant (grant_dm),
        .at_limit (at_limit)
    );

    assign fetch_first = at_limit & if_req;
`else
    // Strict data priority: the starvation limit has no effect in this build.
    assign fetch_first = 1'b0 & (STARVE_LIMIT == 0);
`endif

    // Data wins a tie unless fetch has been starved past the limit.
    assign grant_if = in_idle & if_req & (~dm_req | fetch_first);
    assign grant_dm = in_idle & dm_req & ~grant_if;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= UMA_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            UMA_IDLE:  if (grant_if || grant_dm) state_d = UMA_ISSUE;
            UMA_ISSUE: if (mem_gnt)              state_d = UMA_RESP;
            UMA_RESP:  if (mem_rvalid)           state_d = UMA_IDLE;
            default:                             state_d = UMA_IDLE;
        endcase
    end

    // Owner, stale flag and the registered memory-side request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q   <= UMA_OWN_IF;
            stale_q   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            case (state_q)
                UMA_IDLE: begin
                    stale_q <= 1'b0;
                    if (grant_dm) begin
                        owner_q   <= UMA_OWN_DM;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_be    <= dm_be;
                    end else if (grant_if) begin
                        owner_q   <= UMA_OWN_IF;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_be    <= '1;
                    end
                end
                UMA_ISSUE: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                    end
                    if (if_flush && (owner_q == UMA_OWN_IF)) begin
                        stale_q <= 1'b1;
                    end
                end
                UMA_RESP: begin
                    // The memory still finishes a flushed fetch; only its
                    // completion to the core is suppressed.
                    if (mem_rvalid) begin
                        stale_q <= 1'b0;
                    end else if (if_flush && (owner_q == UMA_OWN_IF)) begin
                        stale_q <= 1'b1;
                    end
                end
                default: begin
                    stale_q <= 1'b0;
                end
            endcase
        end
    end

    // Response routing is combinational so *_valid lands in the rvalid cycle.
    assign resp_fire = (state_q == UMA_RESP) & mem_rvalid;
    assign if_hit    = resp_fire & (owner_q == UMA_OWN_IF);
    assign dm_hit    = resp_fire & (owner_q == UMA_OWN_DM);

    assign if_rdata = if_hit ? mem_rdata : '0;
    assign dm_rdata = dm_hit ? mem_rdata : '0;

    // A requester that dropped its request, or a flushed fetch, gets no pulse.
    assign if_valid = if_hit & if_req & ~stale_q;
    assign dm_valid = dm_hit & dm_req & ~stale_q;

    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;

    assign busy = ~in_idle;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_rdata   (if_rdata),
        .if_valid   (if_valid),
        .if_stall   (if_stall),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_be      (dm_be),
        .dm_rdata   (dm_rdata),
        .dm_valid   (dm_valid),
        .dm_stall   (dm_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int dm_valid_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    // ---------------- memory contents: slave copy and reference copy ----------------
    logic [31:0] smem [logic [31:0]];
    logic [31:0] rmem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] rd_slv(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : init_word(a);
    endfunction

    // ---------------- scoreboard queues: bit 32 = data must match ----------------
    logic [32:0] if_exp [$];
    logic [32:0] dm_exp [$];

    // ---------------- memory slave ----------------
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          cyc;
    } txn_t;

    txn_t glog [$];
    int   gnt_cfg = 0;
    int   rsp_cfg = 0;
    bit   stray_pending = 1'b0;

    function automatic int pick(input int cfg);
        return (cfg < 0) ? int'($urandom_range(0, 3)) : cfg;
    endfunction

    initial begin
        int   s;
        int   cnt;
        txn_t cur;
        s = 0;
        cnt = 0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata = '0;
            if (rst) begin
                s = 0;
            end else begin
                case (s)
                    0: begin
                        if (mem_req) begin
                            cur.addr = mem_addr;
                            cur.we = mem_we;
                            cur.be = mem_be;
                            cur.wdata = mem_wdata;
                            cur.cyc = cyc;
                            glog.push_back(cur);
                            cnt = pick(gnt_cfg);
                            if (cnt == 0) begin
                                mem_gnt = 1'b1;
                                cnt = pick(rsp_cfg);
                                s = 2;
                            end else begin
                                cnt--;
                                s = 1;
                            end
                        end else if (stray_pending) begin
                            mem_rvalid = 1'b1;
                            mem_rdata = 32'hBAD0_BAD0;
                            stray_pending = 1'b0;
                        end
                    end
                    1: begin
                        if (cnt == 0) begin
                            mem_gnt = 1'b1;
                            cnt = pick(rsp_cfg);
                            s = 2;
                        end else begin
                            cnt--;
                        end
                    end
                    default: begin
                        if (cnt == 0) begin
                            mem_rvalid = 1'b1;
                            if (cur.we) begin
                                mem_rdata = $urandom;
                                smem[cur.addr] = merge(rd_slv(cur.addr), cur.wdata, cur.be);
                            end else begin
                                mem_rdata = rd_slv(cur.addr);
                            end
                            s = 0;
                        end else begin
                            cnt--;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk1("if_stall", if_stall, if_req & ~if_valid);
                chk1("dm_stall", dm_stall, dm_req & ~dm_valid);
                chk1("both_valid", if_valid & dm_valid, 1'b0);
                if (if_valid) begin
                    if (if_exp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL if_unexpected: got if_valid=1 data %h, required no completion", if_rdata);
                    end else begin
                        e = if_exp.pop_front();
                        chk32("if_rdata", if_rdata, e[31:0]);
                    end
                end
                if (dm_valid) begin
                    dm_valid_cyc = cyc;
                    if (dm_exp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dm_unexpected: got dm_valid=1 data %h, required no completion", dm_rdata);
                    end else begin
                        e = dm_exp.pop_front();
                        if (e[32]) chk32("dm_rdata", dm_rdata, e[31:0]);
                    end
                end
            end
        end
    end

    // ---------------- requester helpers ----------------
    task automatic wait_if_valid();
        bit got;
        got = 1'b0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (if_valid) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL if_timeout: got no if_valid in 400 cycles, required one");
        end
    endtask

    task automatic wait_dm_valid();
        bit got;
        got = 1'b0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (dm_valid) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL dm_timeout: got no dm_valid in 400 cycles, required one");
        end
    endtask

    task automatic do_fetch(input logic [31:0] a);
        if_req = 1'b1;
        if_addr = a;
        if_exp.push_back({1'b1, rd_ref(a)});
        wait_if_valid();
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic do_dm(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be);
        dm_req = 1'b1;
        dm_we = we;
        dm_addr = a;
        dm_wdata = wd;
        dm_be = be;
        if (we) begin
            rmem[a] = merge(rd_ref(a), wd, be);
            dm_exp.push_back({1'b0, 32'h0});
        end else begin
            dm_exp.push_back({1'b1, rd_ref(a)});
        end
        wait_dm_valid();
        @(posedge clk);
        #1;
        dm_req = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        if_req = 1'b0;
        if_addr = '0;
        if_flush = 1'b0;
        dm_req = 1'b0;
        dm_we = 1'b0;
        dm_addr = '0;
        dm_wdata = '0;
        dm_be = '0;
        smem[32'h100] = 32'h0050_0093;
        rmem[32'h100] = 32'h0050_0093;
        smem[32'h108] = 32'h0000_1234;
        rmem[32'h108] = 32'h0000_1234;

        // Reset values
        idle_cycles(2);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_be", {28'h0, mem_be}, 32'h0);
        chk1("rst_if_valid", if_valid, 1'b0);
        chk1("rst_dm_valid", dm_valid, 1'b0);
        rst = 1'b0;
        idle_cycles(2);

        // Single fetch: grant in cycle 1, response in cycle 3
        gnt_cfg = 0;
        rsp_cfg = 1;
        if_req = 1'b1;
        if_addr = 32'h100;
        if_exp.push_back({1'b1, 32'h0050_0093});
        @(negedge clk);
        chk1("sf_c0_stall", if_stall, 1'b1);
        chk1("sf_c0_mem_req", mem_req, 1'b0);
        @(negedge clk);
        chk1("sf_c1_mem_req", mem_req, 1'b1);
        chk32("sf_c1_mem_addr", mem_addr, 32'h100);
        chk1("sf_c1_mem_we", mem_we, 1'b0);
        chk32("sf_c1_mem_be", {28'h0, mem_be}, 32'hF);
        @(negedge clk);
        chk1("sf_c2_valid", if_valid, 1'b0);
        chk1("sf_c2_stall", if_stall, 1'b1);
        chk1("sf_c2_busy", busy, 1'b1);
        @(negedge clk);
        chk1("sf_c3_valid", if_valid, 1'b1);
        chk32("sf_c3_rdata", if_rdata, 32'h0050_0093);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        idle_cycles(2);

        // Simultaneous requests: store first, fetch request two cycles after dm_valid
        gnt_cfg = 0;
        rsp_cfg = 0;
        glog.delete();
        fork
            do_dm(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011);
            do_fetch(32'h104);
        join
        if (glog.size() < 2) begin
            checks++;
            errors++;
            $display("FAIL simul_log: got %0d memory transactions, required 2", glog.size());
        end else begin
            chk32("simul_first_addr", glog[0].addr, 32'h2000);
            chk1("simul_first_we", glog[0].we, 1'b1);
            chk32("simul_first_be", {28'h0, glog[0].be}, 32'h3);
            chk32("simul_first_wdata", glog[0].wdata, 32'hDEAD_BEEF);
            chk32("simul_second_addr", glog[1].addr, 32'h104);
            chk1("simul_second_we", glog[1].we, 1'b0);
            chk32("simul_fetch_gap", 32'(glog[1].cyc - dm_valid_cyc), 32'd2);
        end
        idle_cycles(2);

        // Grant withheld five cycles: request must stay put
        gnt_cfg = 5;
        rsp_cfg = 0;
        fork
            do_dm(1'b0, 32'h2000, 32'h0, 4'h0);
            begin
                @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk1("stall_mem_req", mem_req, 1'b1);
                    chk32("stall_mem_addr", mem_addr, 32'h2000);
                end
            end
        join
        idle_cycles(2);

        // Flush during RESP of fetch 0x108, redirect to 0x200
        gnt_cfg = 0;
        rsp_cfg = 2;
        if_req = 1'b1;
        if_addr = 32'h108;
        idle_cycles(2);
        if_flush = 1'b1;
        if_addr = 32'h200;
        if_exp.push_back({1'b1, rd_ref(32'h200)});
        idle_cycles(1);
        if_flush = 1'b0;
        @(negedge clk);
        chk1("flush_c3_valid", if_valid, 1'b0);
        @(negedge clk);
        chk1("flush_c4_valid", if_valid, 1'b0);
        chk1("flush_c4_busy", busy, 1'b1);
        @(negedge clk);
        chk1("flush_c5_busy", busy, 1'b0);
        wait_if_valid();
        @(posedge clk);
        #1;
        if_req = 1'b0;
        idle_cycles(2);

        // Reset while in RESP, then a stray response in IDLE
        gnt_cfg = 0;
        rsp_cfg = 10;
        if_req = 1'b1;
        if_addr = 32'h300;
        idle_cycles(3);
        rst = 1'b1;
        if_req = 1'b0;
        #1;
        chk1("amid_busy", busy, 1'b0);
        chk1("amid_mem_req", mem_req, 1'b0);
        chk1("amid_mem_we", mem_we, 1'b0);
        chk32("amid_mem_addr", mem_addr, 32'h0);
        chk32("amid_mem_be", {28'h0, mem_be}, 32'h0);
        chk32("amid_mem_wdata", mem_wdata, 32'h0);
        chk1("amid_if_valid", if_valid, 1'b0);
        idle_cycles(2);
        rst = 1'b0;
        rsp_cfg = 1;
        idle_cycles(1);
        stray_pending = 1'b1;
        if_req = 1'b1;
        if_addr = 32'h400;
        if_exp.push_back({1'b1, rd_ref(32'h400)});
        @(negedge clk);
        chk1("stray_if_valid", if_valid, 1'b0);
        chk1("stray_dm_valid", dm_valid, 1'b0);
        wait_if_valid();
        @(posedge clk);
        #1;
        if_req = 1'b0;
        idle_cycles(3);

        // Both ports held continuously: grant order
        gnt_cfg = 0;
        rsp_cfg = 0;
        glog.delete();
        fork
            for (int i = 0; i < 10; i++) do_dm(1'b0, 32'h2000 + 32'(4 * i), 32'h0, 4'hF);
            begin
                do_fetch(32'h500);
                do_fetch(32'h504);
            end
        join
        if (glog.size() < 10) begin
            checks++;
            errors++;
            $display("FAIL fair_log: got %0d memory transactions, required at least 10", glog.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
`ifdef UMA_FAIRNESS_EN
                chk1($sformatf("fair_grant_%0d_is_fetch", i), glog[i].addr < 32'h2000, (i % 5) == 4);
`else
                chk1($sformatf("fair_grant_%0d_is_fetch", i), glog[i].addr < 32'h2000, 1'b0);
`endif
            end
        end
        idle_cycles(2);

        // Randomized traffic on both ports
        gnt_cfg = -1;
        rsp_cfg = -1;
        fork
            for (int i = 0; i < 25; i++) begin
                idle_cycles(int'($urandom_range(0, 3)));
                do_fetch(32'(4 * $urandom_range(0, 1023)));
            end
            for (int i = 0; i < 25; i++) begin
                idle_cycles(int'($urandom_range(0, 3)));
                do_dm(1'($urandom_range(0, 1)), 32'h2000 + 32'(4 * $urandom_range(0, 15)),
                      $urandom, 4'($urandom_range(0, 15)));
            end
        join
        idle_cycles(4);

        chk32("if_exp_left", 32'(if_exp.size()), 32'd0);
        chk32("dm_exp_left", 32'(dm_exp.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
